// File: rtl/rr_arb_idx8.sv
// Eight-input round-robin arbiter. It emits a registered winner index plus a valid flag,
// holds each grant until it is released, and can revoke a grant after MAX_HOLD cycles.
module rr_arb_idx8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic       hold_expired
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [2:0]       ptr_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             gnt_valid_reg;
    logic [2:0]       gnt_idx_reg;
    logic             hold_expired_reg;

    logic [7:0]       rot_req;
    logic [2:0]       pick_off;
    logic [2:0]       pick_idx;
    logic             timeout_hit;
    logic             release_now;

    // Rotate the requests so that bit 0 is the requester at ptr. The index
    // arithmetic wraps modulo 8 because it is 3 bits wide.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign rot_req[gi] = req[ptr_reg + 3'(gi)];
    end

    always_comb begin
        pick_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_off = 3'(i);
            end
        end
    end

    assign pick_idx = ptr_reg + pick_off;

    if (MAX_HOLD != 0) begin : g_timeout
        assign timeout_hit = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    assign release_now = done || !req[gnt_idx_reg] || timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            ptr_reg          <= 3'd0;
            hold_cnt_reg     <= '0;
            gnt_valid_reg    <= 1'b0;
            gnt_idx_reg      <= 3'd0;
            hold_expired_reg <= 1'b0;
        end else begin
            hold_expired_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        gnt_idx_reg   <= pick_idx;
                        gnt_valid_reg <= 1'b1;
                        hold_cnt_reg  <= '0;
                        state_reg     <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_cnt_reg != '1) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                    if (release_now) begin
                        gnt_valid_reg    <= 1'b0;
                        ptr_reg          <= gnt_idx_reg + 3'd1;
                        state_reg        <= IDLE;
                        // A release through done or a dropped request takes
                        // priority, so only a pure timeout raises the pulse.
                        hold_expired_reg <= !done && req[gnt_idx_reg];
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt_valid    = gnt_valid_reg;
    assign gnt_idx      = gnt_idx_reg;
    assign hold_expired = hold_expired_reg;

endmodule

// File: tb/tb_rr_arb_idx8.sv
// Directed bench for rr_arb_idx8 with MAX_HOLD=16. Every step checks the values of
// gnt_valid, gnt_idx and hold_expired against values that were worked out by hand.
module tb_rr_arb_idx8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       hold_expired;

    int checks;
    int fails;

    rr_arb_idx8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .gnt_valid    (gnt_valid),
        .gnt_idx      (gnt_idx),
        .hold_expired (hold_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge. Outputs are sampled and inputs are driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic v, input logic [2:0] i, input logic e);
        checks++;
        assert ({gnt_valid, gnt_idx, hold_expired} === {v, i, e})
        else begin
            fails++;
            $error("FAIL %s: got valid=%b idx=%0d exp=%b, want valid=%b idx=%0d exp=%b",
                   tag, gnt_valid, gnt_idx, hold_expired, v, i, e);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        req    = 8'hFF;
        done   = 1'b0;

        // Reset applied while every requester is asking.
        tick();
        chk("reset0", 1'b0, 3'd0, 1'b0);
        tick();
        chk("reset1", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

        // Full rotation 0..7,0 with done in the second grant cycle.
        for (int g = 0; g < 9; g++) begin
            tick();
            chk($sformatf("rot_grant%0d", g), 1'b1, 3'(g % 8), 1'b0);
            tick();
            chk($sformatf("rot_hold%0d", g), 1'b1, 3'(g % 8), 1'b0);
            done = 1'b1;
            tick();
            chk($sformatf("rot_idle%0d", g), 1'b0, 3'(g % 8), 1'b0);
            done = 1'b0;
        end

        // Here ptr is 1. Granting requester 5 moves ptr to 6, and the next search wraps around to 0 and then reaches 2.
        req = 8'h20;
        tick();
        chk("grant5", 1'b1, 3'd5, 1'b0);
        done = 1'b1;
        tick();
        chk("rel5", 1'b0, 3'd5, 1'b0);
        done = 1'b0;
        req  = 8'b0000_0101;
        tick();
        chk("wrap_grant0", 1'b1, 3'd0, 1'b0);
        done = 1'b1;
        tick();
        chk("rel0", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        tick();
        chk("grant2", 1'b1, 3'd2, 1'b0);
        done = 1'b1;
        tick();
        chk("rel2", 1'b0, 3'd2, 1'b0);
        req = 8'h00;
        tick();
        chk("done_idle_ignored", 1'b0, 3'd2, 1'b0);
        done = 1'b0;

        // Timeout: requester 3 holds its request, so the grant lasts exactly 16 cycles.
        req = 8'h08;
        tick();
        chk("to_grant3", 1'b1, 3'd3, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            chk($sformatf("to_hold_c%0d", c), 1'b1, 3'd3, 1'b0);
        end
        tick();
        chk("to_expire", 1'b0, 3'd3, 1'b1);
        tick();
        chk("to_regrant3", 1'b1, 3'd3, 1'b0);

        // A new request on another bit is ignored during a grant, and dropping the grantee's own request releases the grant.
        req = 8'h18;
        tick();
        chk("other_req_ignored", 1'b1, 3'd3, 1'b0);
        req = 8'h10;
        tick();
        chk("drop_release", 1'b0, 3'd3, 1'b0);
        tick();
        chk("grant4", 1'b1, 3'd4, 1'b0);

        // done arrives together with the timeout, which gives a plain release.
        for (int c = 2; c <= 16; c++) begin
            tick();
            chk($sformatf("dt_hold_c%0d", c), 1'b1, 3'd4, 1'b0);
        end
        done = 1'b1;
        tick();
        chk("done_with_timeout", 1'b0, 3'd4, 1'b0);
        done = 1'b0;

        // Reset in the middle of the grant to requester 4. The next search must start from 0.
        tick();
        chk("grant4_again", 1'b1, 3'd4, 1'b0);
        tick();
        chk("grant4_hold", 1'b1, 3'd4, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_reset", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        req = 8'h30;
        tick();
        chk("post_reset_from0", 1'b1, 3'd4, 1'b0);
        req = 8'hFF;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("post_reset_next", 1'b1, 3'd5, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
